// File: rtl/pkt_framer.sv
// rtl/pkt_framer.sv - transmit framer: all-ones header, payload words, sequence word, one frame in flight.
module pkt_framer #(
  parameter  int BUS_SIZE  = 60,
  parameter  int WORD_SIZE = 6,
  parameter  int CNT_W     = 16,
  localparam int WORD_NUM  = BUS_SIZE / WORD_SIZE,
  localparam int PAY_W     = (WORD_NUM - 2) * WORD_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PAY_W-1:0]    in_payload,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic                inj_hdr,
  input  logic                inj_seq,
  output logic [BUS_SIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    tx_frames
);

  typedef enum logic [2:0] {
    ST_RST   = 3'b001,
    ST_FIRST = 3'b010,
    ST_RUN   = 3'b100
  } state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] seq_cnt, seq_cnt_nxt;
  logic [WORD_SIZE-1:0] seq_used, seq_field, hdr;
  logic                 accept, out_fire;

  always_comb begin
    state_nxt   = state;
    seq_cnt_nxt = seq_cnt;
    in_ready    = (state != ST_RST) && (!out_valid || out_ready);
    accept      = in_valid && in_ready;
    out_fire    = out_valid && out_ready;
    seq_used    = (state == ST_FIRST || in_sof) ? '0 : seq_cnt;
    seq_field   = inj_seq ? seq_used + WORD_SIZE'(1) : seq_used;
    hdr         = inj_hdr ? '0 : '1;
    case (state)
      ST_RST: state_nxt = ST_FIRST;
      default: begin
        if (accept) begin
          // Any corrupted frame forces a restart at seq 0, the receiver's resync point.
          if (inj_hdr || inj_seq) begin
            state_nxt = ST_FIRST;
          end else begin
            state_nxt   = ST_RUN;
            seq_cnt_nxt = seq_used + WORD_SIZE'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_RST;
      seq_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      tx_frames <= '0;
    end else begin
      state   <= state_nxt;
      seq_cnt <= seq_cnt_nxt;
      if (accept) begin
        out_data  <= {hdr, in_payload, seq_field};
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (out_fire) tx_frames <= tx_frames + CNT_W'(1);
    end
  end

endmodule
